// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, in-order
// response buffering and a decoder-facing valid/ready queue with redirect flush.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = AW + 1;
    localparam int          SW  = CW + 2;
    localparam logic [31:0] PC0 = {RESET_PC[31:2], 2'b00};

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard_cnt;
    logic [CW-1:0] r_count;

    logic [31:0]   r_tag [DEPTH];
    logic [AW-1:0] r_tag_wr;
    logic [AW-1:0] r_tag_rd;

    logic [31:0]   r_fifo_pc    [DEPTH];
    logic [31:0]   r_fifo_instr [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;

    logic          w_instr_valid;
    logic          w_pop;
    logic [SW-1:0] w_inuse;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic          w_unused;

    assign w_unused = &{1'b0, redirect_pc[1:0]};

    assign w_instr_valid = (r_count != '0);
    assign w_pop         = w_instr_valid && instr_ready;

    // A head entry leaving this cycle frees its slot before any new response can land,
    // which is what lets DEPTH=2 with single-cycle memory sustain one instruction per cycle.
    assign w_inuse     = SW'(r_outstanding) + SW'(r_discard_cnt) + SW'(r_count) - SW'(w_pop);
    assign w_req_valid = rst_n && !redirect_valid && (w_inuse < SW'(DEPTH));
    assign w_accept    = w_req_valid && imem_req_ready;

    assign w_rsp_drop  = imem_rsp_valid && (r_discard_cnt != '0);
    assign w_rsp_keep  = imem_rsp_valid && (r_discard_cnt == '0) && !redirect_valid;

    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;
    assign instr_valid    = w_instr_valid;
    assign instr          = w_instr_valid ? r_fifo_instr[r_rd] : '0;
    assign instr_pc       = w_instr_valid ? r_fifo_pc[r_rd]    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= PC0;
            r_outstanding <= '0;
            r_discard_cnt <= '0;
            r_count       <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_wr          <= '0;
            r_rd          <= '0;
        end else if (redirect_valid) begin
            r_pc          <= {redirect_pc[31:2], 2'b00};
            r_outstanding <= '0;
            r_count       <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
            r_wr          <= '0;
            r_rd          <= '0;
            // Any response this cycle retires one in-flight request, whichever counter owns it.
            r_discard_cnt <= r_discard_cnt + r_outstanding - CW'(imem_rsp_valid);
        end else begin
            if (w_accept) begin
                r_pc     <= r_pc + 32'd4;
                r_tag_wr <= r_tag_wr + 1'b1;
            end
            if (w_rsp_drop) begin
                r_discard_cnt <= r_discard_cnt - 1'b1;
            end
            if (w_rsp_keep) begin
                r_wr     <= r_wr + 1'b1;
                r_tag_rd <= r_tag_rd + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp_keep);
            r_count       <= r_count + CW'(w_rsp_keep) - CW'(w_pop);
        end
    end

    // Payload storage carries no reset; occupancy is tracked entirely by the control above.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (w_rsp_keep) begin
            r_fifo_pc[r_wr]    <= r_tag[r_tag_rd];
            r_fifo_instr[r_wr] <= imem_rsp_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_rsp_keep |-> (r_count < CW'(DEPTH)));

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        (SW'(r_outstanding) + SW'(r_discard_cnt) + SW'(r_count)) <= SW'(DEPTH));

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order latency-k memory, random handshakes and
// redirects, checked against a queue-based model of fetched/stale/buffered instructions.
module tb_instruction_fetch;

    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } fl_t;

    mreq_t       mem_q[$];
    fl_t         m_fl[$];
    logic [31:0] m_fifo[$];
    logic [31:0] m_pc;
    int          cyc;
    int          cfg_k;
    int          n_chk;
    int          n_fail;

    logic        o_valid, o_req, e_valid, e_req;
    logic [31:0] o_pc, o_instr, o_addr, e_pc, e_instr, e_addr;
    bit          dut_acc, m_pop;

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_q.delete();
        m_fl.delete();
        m_fifo.delete();
        m_pc = RPC & ~32'd3;
        cyc  = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs at negedge, sample, predict, advance model and memory.
    task automatic tick(input bit rq, input bit ir, input bit rd, input logic [31:0] rpc);
        fl_t f;
        bit  have_f;
        @(negedge clk);
        imem_req_ready = rq;
        instr_ready    = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        o_valid = instr_valid;  o_pc = instr_pc;  o_instr = instr;
        o_req   = imem_req_valid; o_addr = imem_addr;

        e_valid = (m_fifo.size() != 0);
        e_pc    = e_valid ? m_fifo[0] : 32'h0;
        e_instr = e_valid ? (m_fifo[0] ^ KEY) : 32'h0;
        m_pop   = e_valid && ir;
        e_req   = !rd && ((m_fl.size() + m_fifo.size() - (m_pop ? 1 : 0)) < DEPTH);
        e_addr  = m_pc;

        have_f = 1'b0;
        if (imem_rsp_valid && m_fl.size() != 0) begin
            f = m_fl.pop_front();
            have_f = 1'b1;
        end
        if (m_pop) void'(m_fifo.pop_front());
        if (rd) begin
            m_fifo.delete();
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_pc = rpc & ~32'd3;
        end else begin
            if (have_f && !f.stale) m_fifo.push_back(f.pc);
            if (e_req && rq) begin
                m_fl.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end

        dut_acc = imem_req_valid && rq;
        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (dut_acc) mem_q.push_back('{imem_addr, cyc + cfg_k});
        cyc++;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (imem_req_valid !== 1'b0 || imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL reset_req got valid=%b addr=%h want valid=0 addr=%h", imem_req_valid, imem_addr, RPC);
        end
        n_chk++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out got v=%b i=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc);
        end
        do_reset();
        cfg_k = 1;
        tick(1'b0, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_req !== 1'b1 || o_addr !== RPC) begin
            n_fail++;
            $display("FAIL reset_first_req got valid=%b addr=%h want 1 %h", o_req, o_addr, RPC);
        end
    endtask

    task automatic test_stream();
        do_reset();
        cfg_k = 1;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n_chk++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL stream cyc=%0d got v=%b pc=%h i=%h req=%b a=%h want v=%b pc=%h i=%h req=%b a=%h",
                         i, o_valid, o_pc, o_instr, o_req, o_addr, e_valid, e_pc, e_instr, e_req, e_addr);
            end
            if (i >= 3 && i <= 8) begin
                n_chk++;
                if (o_valid !== 1'b1 || o_pc !== RPC + 32'(4 * (i - 3)) || o_instr !== ((RPC + 32'(4 * (i - 3))) ^ KEY)) begin
                    n_fail++;
                    $display("FAIL stream_rate cyc=%0d got v=%b pc=%h i=%h want pc=%h", i, o_valid, o_pc, o_instr,
                             RPC + 32'(4 * (i - 3)));
                end
            end
        end
    endtask

    task automatic test_stall();
        int          acc;
        logic [31:0] seen[$];
        do_reset();
        cfg_k = 1;
        acc = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            if (dut_acc) acc++;
            n_chk++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got v=%b pc=%h req=%b a=%h want v=%b pc=%h req=%b a=%h",
                         i, o_valid, o_pc, o_req, o_addr, e_valid, e_pc, e_req, e_addr);
            end
            if (i >= 3) begin
                n_chk++;
                if (o_valid !== 1'b1 || o_pc !== RPC) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got v=%b pc=%h want 1 %h", i, o_valid, o_pc, RPC);
                end
            end
        end
        n_chk++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL stall_accepts got %0d want 2", acc);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (o_valid) seen.push_back(o_pc);
            n_chk++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL stall_release step=%0d got v=%b pc=%h want v=%b pc=%h", i, o_valid, o_pc, e_valid, e_pc);
            end
        end
        n_chk++;
        if (seen.size() < 3 || seen[0] !== RPC || seen[1] !== RPC + 32'd4 || seen[2] !== RPC + 32'd8) begin
            n_fail++;
            $display("FAIL stall_order got n=%0d first=%h want 0100,0104,0108", seen.size(),
                     (seen.size() != 0) ? seen[0] : 32'hx);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        cfg_k = 3;
        for (int i = 0; i < 60; i++) begin
            tick((i % 2) == 0, 1'($urandom % 2), 1'b0, 32'h0);
            n_chk++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL toggle step=%0d got v=%b pc=%h req=%b a=%h want v=%b pc=%h req=%b a=%h",
                         i, o_valid, o_pc, o_req, o_addr, e_valid, e_pc, e_req, e_addr);
            end
            n_chk++;
            if (mem_q.size() > DEPTH) begin
                n_fail++;
                $display("FAIL toggle_inflight step=%0d got %0d want <=%0d", i, mem_q.size(), DEPTH);
            end
        end
    endtask

    task automatic test_redirect();
        logic [31:0] first_addr, first_pc;
        bit          got_a, got_p;
        do_reset();
        cfg_k = 3;
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b1, 32'h0000_2003);
        n_chk++;
        if (o_req !== 1'b0 || mem_q.size() != 2) begin
            n_fail++;
            $display("FAIL redirect_cycle got req=%b inflight=%0d want req=0 inflight=2", o_req, mem_q.size());
        end
        got_a = 1'b0; got_p = 1'b0; first_addr = '0; first_pc = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (dut_acc && !got_a) begin first_addr = o_addr; got_a = 1'b1; end
            if (o_valid && !got_p) begin first_pc = o_pc; got_p = 1'b1; end
            n_chk++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL redirect step=%0d got v=%b pc=%h req=%b a=%h want v=%b pc=%h req=%b a=%h",
                         i, o_valid, o_pc, o_req, o_addr, e_valid, e_pc, e_req, e_addr);
            end
        end
        n_chk++;
        if (!got_a || first_addr !== 32'h0000_2000 || !got_p || first_pc !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL redirect_target got addr=%h pc=%h want 00002000 00002000", first_addr, first_pc);
        end
    endtask

    task automatic test_redirect_rsp_pop();
        do_reset();
        cfg_k = 1;
        repeat (4) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h0000_3000);
        n_chk++;
        if (o_req !== 1'b0 || o_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_rsp_pop got req=%b v=%b rsp=%b want 0 1 1", o_req, o_valid, imem_rsp_valid);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_chk++;
        if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL redir_rsp_after got v=%b req=%b a=%h want 0 1 00003000", o_valid, o_req, o_addr);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            n_chk++;
            if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                n_fail++;
                $display("FAIL redir_rsp_follow step=%0d got v=%b pc=%h want v=%b pc=%h", i, o_valid, o_pc, e_valid, e_pc);
            end
        end
    endtask

    task automatic test_random();
        bit          rd;
        logic [31:0] rpc;
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            cfg_k = 1 + int'($urandom % 3);
            for (int i = 0; i < 80; i++) begin
                rd  = ($urandom % 12) == 0;
                rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF8 | 32'($urandom % 8)) : $urandom;
                tick(($urandom % 10) < 7, 1'($urandom % 2), rd, rpc);
                n_chk++;
                if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr || o_req !== e_req || o_addr !== e_addr) begin
                    n_fail++;
                    $display("FAIL random seg=%0d step=%0d got v=%b pc=%h i=%h req=%b a=%h want v=%b pc=%h i=%h req=%b a=%h",
                             seg, i, o_valid, o_pc, o_instr, o_req, o_addr, e_valid, e_pc, e_instr, e_req, e_addr);
                end
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        cfg_k = 1;
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_addr !== 32'hFFFF_FFFC || dut_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_top got a=%h acc=%b want FFFFFFFC 1", o_addr, dut_acc);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_addr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_next got a=%h want 00000000", o_addr);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        n_chk++;
        if (o_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC || o_instr !== (32'hFFFF_FFFC ^ KEY)) begin
            n_fail++;
            $display("FAIL wrap_instr got v=%b pc=%h i=%h want 1 FFFFFFFC %h", o_valid, o_pc, o_instr, 32'hFFFF_FFFC ^ KEY);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || imem_req_valid !== 1'b0 || imem_addr !== RPC) begin
            n_fail++;
            $display("FAIL async_reset got v=%b i=%h pc=%h req=%b a=%h want 0 0 0 0 %h",
                     instr_valid, instr, instr_pc, imem_req_valid, imem_addr, RPC);
        end
        do_reset();
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        n_chk++;
        if (o_valid !== 1'b0 || o_req !== 1'b1 || o_addr !== RPC) begin
            n_fail++;
            $display("FAIL async_reset_release got v=%b req=%b a=%h want 0 1 %h", o_valid, o_req, o_addr, RPC);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cfg_k  = 1;
        test_reset();
        test_stream();
        test_stall();
        test_toggle();
        test_redirect();
        test_redirect_rsp_pop();
        test_random();
        test_wrap_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
